// File: rtl/nios2_debug_mem_arbiter_pkg.sv
// Shared nios2 debug package: widths, arbiter
// FSM state encoding and grant-owner enum.
package nios2_debug_mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_J_ACC,
    ST_J_RD,
    ST_A_ACC,
    ST_A_RD
  } arb_state_e;

  typedef enum logic {
    OWN_JTAG = 1'b0,
    OWN_AV   = 1'b1
  } owner_e;

endpackage

// File: rtl/nios2_debug_rr_grant.sv
// Two-requester round-robin picker; the
// requester not served last wins a tie.
module nios2_debug_rr_grant
  import nios2_debug_mem_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   req_j,
  input  logic   req_a,
  input  logic   take,
  output logic   gnt_valid,
  output owner_e gnt_owner
);

  owner_e last_q;
  owner_e last_d;

  // pick an owner and remember it when taken
  always_comb begin
    gnt_valid = req_j | req_a;
    gnt_owner = OWN_AV;
    unique case ({req_j, req_a})
      2'b11: begin
        gnt_owner = (last_q == OWN_AV) ? OWN_JTAG
                                       : OWN_AV;
      end
      2'b10: gnt_owner = OWN_JTAG;
      default: gnt_owner = OWN_AV;
    endcase
    last_d = last_q;
    if (take && gnt_valid) begin
      last_d = gnt_owner;
    end
  end

  // last grant resets to Avalon so JTAG wins first
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= OWN_AV;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/nios2_debug_mem_arbiter.sv
// Arbitrates the OCI debug RAM between the JTAG
// debug slave and the Avalon debug_mem_slave.
module nios2_debug_mem_arbiter
  import nios2_debug_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                jtag_req,
  input  logic                jtag_wr,
  input  logic [ADDR_W-1:0]   jtag_addr,
  input  logic [DATA_W-1:0]   jtag_wdata,
  output logic [DATA_W-1:0]   jtag_rdata,
  output logic                jtag_ready,
  output logic                jtag_error,
  input  logic                av_read,
  input  logic                av_write,
  input  logic [ADDR_W-1:0]   av_address,
  input  logic [DATA_W-1:0]   av_writedata,
  input  logic [DATA_W/8-1:0] av_byteenable,
  output logic [DATA_W-1:0]   av_readdata,
  output logic                av_waitrequest,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_e state_q, state_d;
  logic              pend_q, pend_d;
  logic              hwr_q, hwr_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] jrdata_q, jrdata_d;
  logic [DATA_W-1:0] avrdata_q, avrdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cur_wr_q, cur_wr_d;

  logic   gnt_valid;
  owner_e gnt_owner;
  logic   jtag_done;
  logic   jtag_accept;

  nios2_debug_rr_grant u_rr (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_j     (pend_q),
    .req_a     (av_read | av_write),
    .take      (state_q == ST_IDLE),
    .gnt_valid (gnt_valid),
    .gnt_owner (gnt_owner)
  );

  assign jtag_done = (state_q == ST_J_RD) |
                     ((state_q == ST_J_ACC) & cur_wr_q);
  // a request landing as the old one retires is new
  assign jtag_accept = jtag_req & (~pend_q | jtag_done);

  // next state, RAM port and JTAG bookkeeping
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    hwr_d       = hwr_q;
    haddr_d     = haddr_q;
    hwdata_d    = hwdata_q;
    ready_d     = ready_q;
    err_d       = err_q;
    jrdata_d    = jrdata_q;
    avrdata_d   = avrdata_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    cur_wr_d    = cur_wr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid && gnt_owner == OWN_JTAG) begin
          state_d     = ST_J_ACC;
          mem_addr_d  = haddr_q;
          mem_be_d    = '1;
          mem_wdata_d = hwdata_q;
          mem_we_d    = hwr_q;
          cur_wr_d    = hwr_q;
        end else if (gnt_valid) begin
          state_d     = ST_A_ACC;
          mem_addr_d  = av_address;
          mem_be_d    = av_byteenable;
          mem_wdata_d = av_writedata;
          mem_we_d    = av_write;
          cur_wr_d    = av_write;
        end
      end
      ST_J_ACC: state_d = cur_wr_q ? ST_IDLE : ST_J_RD;
      ST_J_RD: begin
        jrdata_d = mem_rdata;
        state_d  = ST_IDLE;
      end
      ST_A_ACC: state_d = cur_wr_q ? ST_IDLE : ST_A_RD;
      ST_A_RD: begin
        avrdata_d = mem_rdata;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (jtag_done) begin
      pend_d  = 1'b0;
      ready_d = 1'b1;
    end
    if (jtag_accept) begin
      pend_d   = 1'b1;
      ready_d  = 1'b0;
      err_d    = 1'b0;
      hwr_d    = jtag_wr;
      haddr_d  = jtag_addr;
      hwdata_d = jtag_wdata;
    end else if (jtag_req) begin
      err_d = 1'b1;
    end
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      hwr_q       <= 1'b0;
      haddr_q     <= '0;
      hwdata_q    <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      jrdata_q    <= '0;
      avrdata_q   <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      cur_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      hwr_q       <= hwr_d;
      haddr_q     <= haddr_d;
      hwdata_q    <= hwdata_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      jrdata_q    <= jrdata_d;
      avrdata_q   <= avrdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      cur_wr_q    <= cur_wr_d;
    end
  end

  assign jtag_rdata = jrdata_q;
  assign jtag_ready = ready_q;
  assign jtag_error = err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

  assign av_waitrequest =
    ~(((state_q == ST_A_ACC) & cur_wr_q) |
      (state_q == ST_A_RD));
  assign av_readdata = (state_q == ST_A_RD) ? mem_rdata
                                            : avrdata_q;

endmodule

// File: tb/tb_nios2_debug_mem_arbiter.sv
// Bench for nios2_debug_mem_arbiter: directed
// scenarios plus random traffic vs a model.
module tb_nios2_debug_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          jtag_req, jtag_wr;
  logic [AW-1:0] jtag_addr;
  logic [DW-1:0] jtag_wdata, jtag_rdata;
  logic          jtag_ready, jtag_error;
  logic          av_read, av_write;
  logic [AW-1:0] av_address;
  logic [DW-1:0] av_writedata, av_readdata;
  logic [BW-1:0] av_byteenable;
  logic          av_waitrequest;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nios2_debug_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .jtag_req(jtag_req), .jtag_wr(jtag_wr),
    .jtag_addr(jtag_addr), .jtag_wdata(jtag_wdata),
    .jtag_rdata(jtag_rdata), .jtag_ready(jtag_ready),
    .jtag_error(jtag_error),
    .av_read(av_read), .av_write(av_write),
    .av_address(av_address), .av_writedata(av_writedata),
    .av_byteenable(av_byteenable),
    .av_readdata(av_readdata),
    .av_waitrequest(av_waitrequest),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // RAM fixture: one-cycle read latency
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we)
      for (int b = 0; b < BW; b++)
        if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  // reference model: who owns the RAM and how far
  // into its access it is (0 free, 1 addr, 2 data)
  logic [DW-1:0] sh [256];
  int            m_phase;
  bit            m_av, m_last_av;
  bit            a_wr;
  logic [AW-1:0] a_addr;
  logic [BW-1:0] a_be;
  logic [DW-1:0] a_wd;
  bit            m_pend, m_hwr;
  logic [AW-1:0] m_haddr;
  logic [DW-1:0] m_hwd;
  bit            m_ready, m_err;
  logic [DW-1:0] m_jrd;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_av = 0; m_last_av = 1;
    a_wr = 0; a_addr = '0; a_be = '0; a_wd = '0;
    m_pend = 0; m_hwr = 0; m_haddr = '0; m_hwd = '0;
    m_ready = 0; m_err = 0; m_jrd = '0;
  endtask

  task automatic model_step();
    bit done, old_pend, any_av, pick_av;
    done = !m_av && ((m_phase == 1 && a_wr) || m_phase == 2);
    old_pend = m_pend;
    any_av = av_read || av_write;
    case (m_phase)
      0: if (old_pend || any_av) begin
        if (old_pend && any_av) pick_av = !m_last_av;
        else pick_av = !old_pend;
        m_av = pick_av; m_last_av = pick_av; m_phase = 1;
        if (pick_av) begin
          a_wr = av_write; a_addr = av_address;
          a_be = av_byteenable; a_wd = av_writedata;
        end else begin
          a_wr = m_hwr; a_addr = m_haddr;
          a_be = '1; a_wd = m_hwd;
        end
      end
      1: if (a_wr) begin
        for (int b = 0; b < BW; b++)
          if (a_be[b]) sh[a_addr][8*b +: 8] = a_wd[8*b +: 8];
        m_phase = 0;
      end else m_phase = 2;
      2: begin
        if (!m_av) m_jrd = sh[a_addr];
        m_phase = 0;
      end
      default: m_phase = 0;
    endcase
    if (done) begin m_pend = 0; m_ready = 1; end
    if (jtag_req && (!old_pend || done)) begin
      m_pend = 1; m_ready = 0; m_err = 0;
      m_hwr = jtag_wr; m_haddr = jtag_addr; m_hwd = jtag_wdata;
    end else if (jtag_req) m_err = 1;
  endtask

  task automatic compare();
    chk("mem_we", mem_we, (m_phase == 1 && a_wr));
    chk("mem_addr", mem_addr, a_addr);
    chk("mem_be", mem_be, a_be);
    chk("mem_wdata", mem_wdata, a_wd);
    chk("av_waitrequest", av_waitrequest,
        !(m_av && ((m_phase == 1 && a_wr) || m_phase == 2)));
    if (m_av && m_phase == 2) chk("av_readdata", av_readdata, sh[a_addr]);
    chk("jtag_ready", jtag_ready, m_ready);
    chk("jtag_error", jtag_error, m_err);
    chk("jtag_rdata", jtag_rdata, m_jrd);
  endtask

  // one clock: model, edge, check; the Avalon
  // master drops its command once accepted
  task automatic step();
    bit acc;
    acc = (av_read || av_write) && !av_waitrequest;
    model_step();
    @(posedge clk); #1;
    compare();
    if (acc) begin av_read = 0; av_write = 0; end
  endtask

  task automatic jtag_pulse(bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
    jtag_req = 1; jtag_wr = wr; jtag_addr = a; jtag_wdata = d;
    step();
    jtag_req = 0;
  endtask

  task automatic wait_ready(int lim);
    for (int i = 0; i < lim; i++) begin
      if (jtag_ready) break;
      step();
    end
    chk("jtag_ready_timeout", jtag_ready, 1);
  endtask

  task automatic do_reset();
    reset_n = 0; jtag_req = 0; av_read = 0; av_write = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_waitrequest", av_waitrequest, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_jtag_ready", jtag_ready, 0);
    chk("rst_jtag_error", jtag_error, 0);
    chk("rst_jtag_rdata", jtag_rdata, 0);
    chk("rst_av_readdata", av_readdata, 0);
    reset_n = 1;
  endtask

  int lows, wes;
  logic [DW-1:0] rd;
  logic [BW-1:0] be_seen;

  initial begin
    reset_n = 1; jtag_req = 0; jtag_wr = 0;
    jtag_addr = '0; jtag_wdata = '0;
    av_read = 0; av_write = 0; av_address = '0;
    av_writedata = '0; av_byteenable = '0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = $urandom; sh[i] = ram[i];
    end
    #2;
    do_reset();
    step();
    chk("idle_after_reset", mem_we, 0);

    // JTAG read of a known word
    ram[8'h10] = 32'hDEADBEEF; sh[8'h10] = 32'hDEADBEEF;
    jtag_pulse(0, 8'h10, '0);
    chk("j_rd_ready_low", jtag_ready, 0);
    step();
    chk("j_rd_addr", mem_addr, 8'h10);
    chk("j_rd_we", mem_we, 0);
    step();
    chk("j_rd_ready_mid", jtag_ready, 0);
    step();
    chk("j_rd_data", jtag_rdata, 32'hDEADBEEF);
    chk("j_rd_ready", jtag_ready, 1);

    // JTAG write and Avalon read both pending
    do_reset();
    jtag_pulse(1, 8'h20, 32'h12345678);
    av_read = 1; av_address = 8'h20;
    step();
    chk("both_j_first_we", mem_we, 1);
    chk("both_j_first_addr", mem_addr, 8'h20);
    chk("both_j_first_wait", av_waitrequest, 1);
    lows = 0; rd = '0;
    for (int i = 0; i < 8; i++) begin
      if (!av_waitrequest) begin lows++; rd = av_readdata; end
      step();
    end
    chk("both_av_low_cycles", lows, 1);
    chk("both_av_data", rd, 32'h12345678);

    // overrun while a JTAG access is pending
    ram[8'h30] = 32'hA5A50030; sh[8'h30] = 32'hA5A50030;
    jtag_pulse(0, 8'h30, '0);
    jtag_pulse(1, 8'h40, 32'hFFFF0000);
    chk("ovr_error", jtag_error, 1);
    chk("ovr_addr_kept", mem_addr, 8'h30);
    chk("ovr_no_write", mem_we, 0);
    wait_ready(8);
    chk("ovr_rdata", jtag_rdata, 32'hA5A50030);
    chk("ovr_sticky", jtag_error, 1);
    jtag_pulse(0, 8'h30, '0);
    chk("ovr_cleared", jtag_error, 0);
    wait_ready(8);

    // Avalon byte-enabled write
    ram[8'h50] = 32'h11223344; sh[8'h50] = 32'h11223344;
    av_write = 1; av_address = 8'h50;
    av_writedata = 32'hAABBCCDD; av_byteenable = 4'b0101;
    lows = 0; wes = 0; be_seen = '0;
    for (int i = 0; i < 6; i++) begin
      if (!av_waitrequest) lows++;
      step();
      if (mem_we) begin wes++; be_seen = mem_be; end
    end
    chk("be_we_cycles", wes, 1);
    chk("be_mem_be", be_seen, 4'b0101);
    chk("be_low_cycles", lows, 1);
    jtag_pulse(0, 8'h50, '0);
    wait_ready(8);
    chk("be_merged", jtag_rdata, 32'h11BB33DD);

    // reset in the middle of an Avalon read
    ram[8'h60] = 32'h600D0060; sh[8'h60] = 32'h600D0060;
    av_read = 1; av_address = 8'h60;
    for (int i = 0; i < 6; i++) begin
      if (m_av && m_phase == 2) break;
      step();
    end
    chk("a_rd_reached", av_waitrequest, 0);
    reset_n = 0;
    #1;
    chk("midrst_wait", av_waitrequest, 1);
    chk("midrst_we", mem_we, 0);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1;
    lows = 0; rd = '0;
    for (int i = 0; i < 8; i++) begin
      if (!av_waitrequest) begin lows++; rd = av_readdata; end
      step();
    end
    chk("reissue_low_cycles", lows, 1);
    chk("reissue_data", rd, 32'h600D0060);

    // streaming Avalon reads with periodic JTAG
    av_read = 1; av_address = 8'($urandom_range(0, 15));
    for (int r = 0; r < 6; r++) begin
      jtag_pulse(0, 8'($urandom_range(0, 15)), '0);
      if (!av_read) begin
        av_read = 1; av_address = 8'($urandom_range(0, 15));
      end
      lows = 0;
      for (int i = 0; i < 12; i++) begin
        if (jtag_ready) break;
        if (!av_waitrequest) lows++;
        step();
        if (!av_read) begin
          av_read = 1; av_address = 8'($urandom_range(0, 15));
        end
      end
      chk("stream_jtag_done", jtag_ready, 1);
      chk("stream_jtag_wait", (lows <= 1), 1);
      repeat (2) begin
        step();
        if (!av_read) begin
          av_read = 1; av_address = 8'($urandom_range(0, 15));
        end
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (!av_read) break;
      step();
    end
    av_read = 0;

    // random mixed traffic
    for (int c = 0; c < 500; c++) begin
      jtag_req = ($urandom_range(0, 5) == 0);
      jtag_wr = 1'($urandom);
      jtag_addr = 8'($urandom_range(0, 15));
      jtag_wdata = $urandom;
      if (!av_read && !av_write && $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 1) == 1) av_write = 1;
        else av_read = 1;
        av_address = 8'($urandom_range(0, 15));
        av_writedata = $urandom;
        av_byteenable = 4'($urandom);
      end
      step();
    end
    jtag_req = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
